// File: rtl/serial_bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    M_OWN,
    S_CMD,
    S_OWN,
    TURNAROUND
  } arb_state_t;

  localparam int BUS_TURNAROUND_CYCLES = 1;

  // Never returns less than 1 so single-entry vectors keep a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational one-hot picker: searches upward from i_ptr with wrap.
// With i_ptr = 0 this is plain lowest-index-wins priority.
module rr_priority_picker
  import serial_bus_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]          i_req,
  input  logic [clog2(N)-1:0]   i_ptr,
  output logic [N-1:0]          o_pick,
  output logic                  o_pick_valid
);

  localparam int PW = clog2(N);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_pick       = '0;
    o_pick_valid = 1'b0;
    w_idx        = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(i_ptr) + i) % N);
      if (!o_pick_valid && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_pick_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Bus arbiter / tenure sequencer for the shared serial bus. Slave returns
// always beat masters. Define ARB_ROUND_ROBIN_EN for round-robin masters.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int  MASTER_COUNT   = 3,
  parameter int  SLAVE_COUNT    = 3,
  parameter int  TIMEOUT_CYCLES = 200,
  localparam int IDW = clog2((MASTER_COUNT > SLAVE_COUNT) ? MASTER_COUNT : SLAVE_COUNT)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [MASTER_COUNT-1:0] i_m_req,
  input  logic [SLAVE_COUNT-1:0]  i_s_req,
  output logic [MASTER_COUNT-1:0] o_m_grant,
  output logic [SLAVE_COUNT-1:0]  o_s_cmd,
  output logic                    o_bus_util,
  output logic [IDW-1:0]          o_owner_id,
  output logic                    o_owner_is_slave,
  output logic                    o_timeout_err
);

  localparam int MPW = clog2(MASTER_COUNT);
  localparam int CW  = clog2(TIMEOUT_CYCLES + 1);

  arb_state_t              r_state;
  logic [MASTER_COUNT-1:0] r_m_req;
  logic [SLAVE_COUNT-1:0]  r_s_req;
  logic [IDW-1:0]          r_id;
  logic                    r_slv;
  logic [CW-1:0]           r_cnt;

  logic [MPW-1:0]          w_ptr;
  logic [MASTER_COUNT-1:0] w_m_pick;
  logic [SLAVE_COUNT-1:0]  w_s_pick;
  logic                    w_m_vld, w_s_vld;
  logic [IDW-1:0]          w_m_idx, w_s_idx;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_to, w_owner_req;

  rr_priority_picker #(.N(MASTER_COUNT)) u_m_pick (
    .i_req(r_m_req), .i_ptr(w_ptr), .o_pick(w_m_pick), .o_pick_valid(w_m_vld)
  );

  rr_priority_picker #(.N(SLAVE_COUNT)) u_s_pick (
    .i_req(r_s_req), .i_ptr('0), .o_pick(w_s_pick), .o_pick_valid(w_s_vld)
  );

  always_comb begin
    w_m_idx = '0;
    w_s_idx = '0;
    for (int i = 0; i < MASTER_COUNT; i++) if (w_m_pick[i]) w_m_idx = IDW'(i);
    for (int i = 0; i < SLAVE_COUNT; i++)  if (w_s_pick[i]) w_s_idx = IDW'(i);
  end

  assign w_cnt_nxt   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_to        = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CW'(TIMEOUT_CYCLES));
  assign w_owner_req = r_slv ? r_s_req[r_id] : r_m_req[r_id];

`ifdef ARB_ROUND_ROBIN_EN
  logic [MPW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 r_ptr <= '0;
    else if (r_state == TURNAROUND && !r_slv)  r_ptr <= MPW'((int'(r_id) + 1) % MASTER_COUNT);
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Requests are registered first; all outputs are set on the state transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state          <= IDLE;
      r_m_req          <= '0;
      r_s_req          <= '0;
      r_id             <= '0;
      r_slv            <= 1'b0;
      r_cnt            <= '0;
      o_m_grant        <= '0;
      o_s_cmd          <= '0;
      o_bus_util       <= 1'b1;
      o_owner_id       <= '0;
      o_owner_is_slave <= 1'b0;
      o_timeout_err    <= 1'b0;
    end else begin
      r_m_req       <= i_m_req;
      r_s_req       <= i_s_req;
      o_s_cmd       <= '0;
      o_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_s_vld) begin
            r_state          <= S_CMD;
            r_id             <= w_s_idx;
            r_slv            <= 1'b1;
            r_cnt            <= '0;
            o_s_cmd          <= w_s_pick;
            o_bus_util       <= 1'b0;
            o_owner_id       <= w_s_idx;
            o_owner_is_slave <= 1'b1;
          end else if (w_m_vld) begin
            r_state          <= M_OWN;
            r_id             <= w_m_idx;
            r_slv            <= 1'b0;
            r_cnt            <= '0;
            o_m_grant        <= w_m_pick;
            o_bus_util       <= 1'b0;
            o_owner_id       <= w_m_idx;
            o_owner_is_slave <= 1'b0;
          end
        end
        S_CMD: begin
          r_state <= S_OWN;
          r_cnt   <= w_cnt_nxt;
        end
        M_OWN, S_OWN: begin
          r_cnt <= w_cnt_nxt;
          // A release seen on the timeout cycle is a clean release, not an error.
          if (!w_owner_req || w_to) begin
            r_state          <= TURNAROUND;
            r_cnt            <= '0;
            o_m_grant        <= '0;
            o_bus_util       <= 1'b1;
            o_owner_id       <= '0;
            o_owner_is_slave <= 1'b0;
            o_timeout_err    <= w_owner_req;
          end
        end
        TURNAROUND: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == CW'(BUS_TURNAROUND_CYCLES - 1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed scenarios plus random traffic
// checked against a tenure-level reference model.
module tb_serial_bus_arbiter;

  localparam int M  = 3;
  localparam int S  = 3;
  localparam int TO = 10;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [M-1:0] m_req, m_grant;
  logic [S-1:0] s_req, s_cmd;
  logic         bus_util, owner_is_slave, timeout_err;
  logic [1:0]   owner_id;
  logic [2:0]   ONE = 3'b001;

  int total = 0;
  int bad   = 0;

  serial_bus_arbiter #(.MASTER_COUNT(M), .SLAVE_COUNT(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .i_m_req(m_req), .i_s_req(s_req),
    .o_m_grant(m_grant), .o_s_cmd(s_cmd), .o_bus_util(bus_util),
    .o_owner_id(owner_id), .o_owner_is_slave(owner_is_slave), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, for how long, and the free gap after it.
  int         mo_owner, mo_ten, mo_gap, mo_ptr;
  bit         mo_slv, mo_err;
  logic [2:0] mo_pm, mo_ps;

  task automatic model_reset();
    mo_owner = -1; mo_ten = 0; mo_gap = 0; mo_ptr = 0;
    mo_slv = 1'b0; mo_err = 1'b0; mo_pm = '0; mo_ps = '0;
  endtask

  task automatic model_edge();
    bit         keep;
    int         p;
    logic [2:0] t;
    mo_err = 1'b0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (mo_owner >= 0) begin
      mo_ten++;
      t    = mo_slv ? (mo_ps >> mo_owner) : (mo_pm >> mo_owner);
      keep = t[0];
      if (mo_slv && mo_ten == 1) keep = 1'b1;
      else if (keep && TO != 0 && mo_ten == TO) begin
        keep   = 1'b0;
        mo_err = 1'b1;
      end
      if (!keep) begin
        if (!mo_slv && RR) mo_ptr = (mo_owner + 1) % M;
        mo_owner = -1;
        mo_gap   = 1;
      end
    end else if (mo_gap > 0) begin
      mo_gap--;
    end else if (mo_ps != 0) begin
      p = -1;
      for (int i = S - 1; i >= 0; i--) begin
        t = mo_ps >> i;
        if (t[0]) p = i;
      end
      mo_owner = p; mo_slv = 1'b1; mo_ten = 0;
    end else if (mo_pm != 0) begin
      p = -1;
      for (int k = M - 1; k >= 0; k--) begin
        t = mo_pm >> ((mo_ptr + k) % M);
        if (t[0]) p = (mo_ptr + k) % M;
      end
      mo_owner = p; mo_slv = 1'b0; mo_ten = 0;
    end
    mo_pm = m_req;
    mo_ps = s_req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; m_req = '0; s_req = '0;
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; m_req = '0; s_req = '0;
    model_reset();
    @(posedge clk);
    #1;
    total++; if (m_grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b want=000", m_grant); end
    total++; if (s_cmd !== 3'b000) begin bad++; $display("FAIL reset_scmd got=%b want=000", s_cmd); end
    total++; if (bus_util !== 1'b1) begin bad++; $display("FAIL reset_util got=%b want=1", bus_util); end
    total++; if (owner_id !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner_id); end
    total++; if (owner_is_slave !== 1'b0) begin bad++; $display("FAIL reset_isslv got=%b want=0", owner_is_slave); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_toerr got=%b want=0", timeout_err); end
    rstn = 1'b1;
  endtask

  task automatic test_basic_grant();
    m_req = 3'b010;
    tick();
    total++; if (m_grant !== 3'b000) begin bad++; $display("FAIL basic_early got=%b want=000", m_grant); end
    tick();
    total++; if (m_grant !== 3'b010) begin bad++; $display("FAIL basic_grant got=%b want=010", m_grant); end
    total++; if (bus_util !== 1'b0) begin bad++; $display("FAIL basic_util got=%b want=0", bus_util); end
    total++; if (owner_id !== 2'd1) begin bad++; $display("FAIL basic_owner got=%0d want=1", owner_id); end
    m_req = 3'b000;
    tick();
    total++; if (m_grant !== 3'b010) begin bad++; $display("FAIL basic_hold got=%b want=010", m_grant); end
    tick();
    total++; if ({m_grant, bus_util} !== 4'b0001) begin bad++; $display("FAIL basic_turn got=%b want=0001", {m_grant, bus_util}); end
    tick();
    total++; if ({m_grant, bus_util} !== 4'b0001) begin bad++; $display("FAIL basic_idle got=%b want=0001", {m_grant, bus_util}); end
  endtask

  task automatic test_rr_order();
    int order[4];
    int want[4];
    int n;
    if (RR) begin want[0] = 0; want[1] = 1; want[2] = 2; want[3] = 0; end
    else    begin want[0] = 0; want[1] = 0; want[2] = 0; want[3] = 0; end
    apply_reset();
    m_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (m_grant === 3'b000 && n < 20) begin tick(); n++; end
      if (m_grant === 3'b000) begin
        total++; bad++;
        $display("FAIL rr_wait got=%b want=nonzero within 20 cycles", m_grant);
        order[k] = -1;
      end else begin
        order[k] = int'(owner_id);
        m_req = m_req & ~(ONE << owner_id);
        tick();
        m_req = 3'b111;
        tick();
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (order[k] != want[k]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, order[k], want[k]); end
    end
    m_req = '0;
    repeat (4) tick();
  endtask

  task automatic test_slave_priority();
    bit leak;
    apply_reset();
    s_req = 3'b100; m_req = 3'b001;
    tick();
    tick();
    total++; if ({s_cmd, m_grant, bus_util} !== 7'b1000000) begin bad++; $display("FAIL slv_cmd got=%b want=1000000", {s_cmd, m_grant, bus_util}); end
    tick();
    total++; if ({s_cmd, owner_is_slave, owner_id} !== 6'b000110) begin bad++; $display("FAIL slv_own got=%b want=000110", {s_cmd, owner_is_slave, owner_id}); end
    leak = 1'b0;
    repeat (3) begin tick(); if (m_grant !== 3'b000 || s_cmd !== 3'b000) leak = 1'b1; end
    total++; if (leak) begin bad++; $display("FAIL slv_hold got=leak want=no grant/cmd"); end
    s_req = 3'b000;
    tick();
    total++; if (bus_util !== 1'b0) begin bad++; $display("FAIL slv_release got=%b want=0", bus_util); end
    tick();
    total++; if ({m_grant, bus_util} !== 4'b0001) begin bad++; $display("FAIL slv_turn got=%b want=0001", {m_grant, bus_util}); end
    tick();
    total++; if ({m_grant, bus_util} !== 4'b0001) begin bad++; $display("FAIL slv_gap got=%b want=0001", {m_grant, bus_util}); end
    tick();
    total++; if (m_grant !== 3'b001) begin bad++; $display("FAIL slv_mgrant got=%b want=001", m_grant); end
    m_req = '0;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    logic g[30];
    logic e[30];
    int   first, len, esum;
    apply_reset();
    m_req = 3'b001;
    for (int c = 0; c < 30; c++) begin
      tick();
      g[c] = m_grant[0];
      e[c] = timeout_err;
    end
    first = -1;
    for (int c = 29; c >= 0; c--) if (g[c] === 1'b1) first = c;
    len = 0;
    if (first >= 0) while (first + len < 30 && g[first + len] === 1'b1) len++;
    total++; if (first != 1) begin bad++; $display("FAIL to_first got=%0d want=1", first); end
    total++; if (len != TO) begin bad++; $display("FAIL to_len got=%0d want=%0d", len, TO); end
    if (first >= 0 && first + len + 2 < 30) begin
      esum = 0;
      for (int c = 0; c <= first + len + 1; c++) if (e[c] === 1'b1) esum++;
      total++; if (e[first + len] !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", e[first + len]); end
      total++; if (esum != 1) begin bad++; $display("FAIL to_count got=%0d want=1", esum); end
      total++; if ({g[first + len + 1], g[first + len + 2]} !== 2'b01) begin bad++; $display("FAIL to_regrant got=%b want=01", {g[first + len + 1], g[first + len + 2]}); end
    end else begin
      total++; bad++; $display("FAIL to_window got=first %0d len %0d want=window inside 30 cycles", first, len);
    end
    m_req = '0;
    repeat (4) tick();
  endtask

  task automatic test_release_at_timeout();
    apply_reset();
    m_req = 3'b001;
    tick();
    tick();
    total++; if (m_grant !== 3'b001) begin bad++; $display("FAIL rel_grant got=%b want=001", m_grant); end
    repeat (8) tick();
    m_req = 3'b000;
    tick();
    total++; if (m_grant !== 3'b001) begin bad++; $display("FAIL rel_hold got=%b want=001", m_grant); end
    tick();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rel_toerr got=%b want=0", timeout_err); end
    total++; if ({m_grant, bus_util} !== 4'b0001) begin bad++; $display("FAIL rel_drop got=%b want=0001", {m_grant, bus_util}); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_sown();
    apply_reset();
    s_req = 3'b010;
    repeat (3) tick();
    total++; if ({owner_is_slave, owner_id, bus_util} !== 4'b1010) begin bad++; $display("FAIL mid_sown got=%b want=1010", {owner_is_slave, owner_id, bus_util}); end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({m_grant, s_cmd, bus_util, owner_id, owner_is_slave, timeout_err} !== 11'b00000010000) begin
      bad++; $display("FAIL mid_reset got=%b want=00000010000", {m_grant, s_cmd, bus_util, owner_id, owner_is_slave, timeout_err});
    end
    model_reset();
    tick();
    rstn = 1'b1; s_req = '0;
  endtask

  task automatic test_random();
    logic [M-1:0] eg;
    logic [S-1:0] es;
    logic [1:0]   eid;
    logic [10:0]  exp_v, got_v;
    logic [2:0]   t;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < M; i++) if ($urandom_range(5) == 0) m_req = m_req ^ (ONE << i);
      for (int i = 0; i < S; i++) begin
        t = s_req >> i;
        if (t[0]) begin if ($urandom_range(5) == 0) s_req = s_req ^ (ONE << i); end
        else if ($urandom_range(39) == 0) s_req = s_req ^ (ONE << i);
      end
      tick();
      eg = '0; es = '0; eid = '0;
      if (mo_owner >= 0) begin
        eid = 2'(mo_owner);
        if (!mo_slv) eg = ONE << mo_owner;
        else if (mo_ten == 0) es = ONE << mo_owner;
      end
      exp_v = {eg, es, (mo_owner < 0), eid, (mo_owner >= 0 && mo_slv), mo_err};
      got_v = {m_grant, s_cmd, bus_util, owner_id, owner_is_slave, timeout_err};
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b want=%b", c, got_v, exp_v); end
    end
  endtask

  initial begin
    m_req = '0; s_req = '0; rstn = 1'b0;
    test_reset();
    test_basic_grant();
    test_rr_order();
    test_slave_priority();
    test_timeout();
    test_release_at_timeout();
    test_reset_mid_sown();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Arbiter and tenure sequencer for the shared single-wire serial data bus. It grants the bus to one master at a time and returns the bus to slaves that finished a split read or write and now need to send data or an acknowledgement. It drives the `bus_util` idle indication and the per-slave `arbiter_cmd_in` strobes consumed by every slave, and sits beside the bus at top level.

## Interface
- `MASTER_COUNT`, 3: number of requesting masters.
- `SLAVE_COUNT`, 3: number of slaves able to request a return tenure.
- `TIMEOUT_CYCLES`, 200: maximum tenure length in clk cycles; 0 disables the timeout.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `m_req`  in  MASTER_COUNT  level request per master; held high for the whole tenure; falling edge = release.
- `s_req`  in  SLAVE_COUNT  level return request per slave (data ready / write done); held high until its transmission ends.
- `m_grant`  out  MASTER_COUNT  one-hot master grant, level.
- `s_cmd`  out  SLAVE_COUNT  one-hot, one-cycle strobe to a slave's `arbiter_cmd_in`.
- `bus_util`  out  1  high when no tenure is active (bus free).
- `owner_id`  out  clog2(max(MASTER_COUNT,SLAVE_COUNT))  index of current owner; 0 when idle.
- `owner_is_slave`  out  1  qualifies `owner_id`.
- `timeout_err`  out  1  one-cycle pulse on forced release.

## Operation
- Reset values:
  - `m_grant` = 0, `s_cmd` = 0, `bus_util` = 1.
  - `owner_id` = 0, `owner_is_slave` = 0, `timeout_err` = 0.
  - State IDLE, round-robin pointer = 0.
- States: IDLE, M_OWN, S_CMD, S_OWN, TURNAROUND.
- **IDLE**
  - Samples requests only in this state.
  - Any `s_req` set: go to S_CMD with the lowest-index slave. Slaves always beat masters so that split transactions drain.
  - Otherwise, any `m_req` set: go to M_OWN with the master chosen by the picker.
  - `bus_util` stays 1 until the state changes.
- **M_OWN**
  - `m_grant[id]` = 1, `bus_util` = 0.
  - On `m_req[id]` = 0, or on timeout: go to TURNAROUND.
- **S_CMD**
  - `s_cmd[id]` = 1 for exactly one cycle, `bus_util` = 0.
  - Always followed by S_OWN.
- **S_OWN**
  - `bus_util` = 0.
  - On `s_req[id]` = 0, or on timeout: go to TURNAROUND.
- **TURNAROUND**
  - Lasts one cycle; all grants are 0 and `bus_util` = 1, letting the line pull high and slaves in WAIT_FOR_PEER return to IDLE.
  - Advances the round-robin pointer to owner+1 (mod MASTER_COUNT) if the owner was a master.
  - Then IDLE.
- **Tenure counter**
  - Width clog2(TIMEOUT_CYCLES+1). Cleared on entry to M_OWN or S_CMD; increments each owned cycle and saturates.
  - When count equals TIMEOUT_CYCLES: drop the grant, pulse `timeout_err`, go to TURNAROUND.
- **Boundary conditions**
  - Release and timeout in the same cycle: release wins and `timeout_err` stays 0.
  - A requester still high after a timeout is re-arbitrated normally from IDLE.
  - A request that drops before IDLE samples it is ignored.
  - `m_req` of a non-owner changing mid-tenure has no effect.
  - A reset mid-tenure returns every output to its reset value immediately (asynchronous).

## Timing
- Request to grant: `m_req` high in IDLE at edge N gives `m_grant` high after edge N+1.
- `s_req` at edge N gives `s_cmd` high for the cycle after edge N+1.
- Release to next grant: `m_req` low at edge N puts TURNAROUND after N+1; the next grant is visible after N+3. The minimum bus gap is 2 cycles with `bus_util` = 1.
- `m_grant` and `s_cmd` are registered outputs: no combinational path from any request to any output.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: master selection is round-robin starting at the pointer, searching upward with wrap.
- Not defined: fixed priority, lowest master index wins. The pointer register is omitted.
- Slave selection is fixed lowest-index in both builds.

## Structure
- Package `serial_bus_pkg` holds:
  - the state enum `arb_state_t`;
  - the `BUS_TURNAROUND_CYCLES` constant (1);
  - a shared `clog2` helper for the ID width.
- Sub-module `rr_priority_picker` (parameter N): inputs `req[N]` and `ptr`; outputs one-hot `pick` and `pick_valid`. It is combinational and degenerates to fixed priority when `ptr` = 0.

## Test plan
- Reset, then `m_req` = 3'b010 → `m_grant` = 3'b010 two edges later, `bus_util` = 0. Drop `m_req` → `bus_util` high for 1 cycle, then idle.
- `m_req` = 3'b111 held with repeated releases (ARB_ROUND_ROBIN_EN) → grant order 0, 1, 2, 0. Without the macro → 0, 0, 0.
- `s_req[2]` and `m_req[0]` rise together → `s_cmd` = 3'b100 for exactly one cycle, and `m_grant` stays 0 until `s_req[2]` drops plus 1 turnaround cycle.
- `TIMEOUT_CYCLES` = 10, master holds `m_req` for 30 cycles → grant drops after 10 owned cycles, `timeout_err` pulses once, then the master is re-granted.
- Release on exactly the timeout cycle → `timeout_err` = 0.
- `rstn` low mid-S_OWN → all outputs return to reset values at once and `bus_util` = 1.
